// File: rtl/dscope_sync_pkg.sv
// Shared definitions for the sync-strobe initiator and the multi-clock sync distributor bench.
package dscope_sync_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_PULSE = 2'd2,
        ST_HOLD  = 2'd3
    } sync_state_e;

    localparam int BURST_W     = 16;
    localparam int DEF_PULSE_W = 4;
    localparam int DEF_HOLDOFF = 16;

    function automatic logic [BURST_W-1:0] sat_inc(input logic [BURST_W-1:0] v);
        return (v == {BURST_W{1'b1}}) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sync_gen_trig_sync.sv
// Two-flop synchroniser plus rising-edge detector; emits a one-cycle pulse per external edge.
module trig_sync (
    input  logic sys_clk,
    input  logic rst,
    input  logic async_in,
    output logic pulse
);

    logic meta_r;
    logic sync_r;
    logic prev_r;
    logic pulse_r;

    // Synchronise the asynchronous input and register its rising edge.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            meta_r  <= 1'b0;
            sync_r  <= 1'b0;
            prev_r  <= 1'b0;
            pulse_r <= 1'b0;
        end else begin
            meta_r  <= async_in;
            sync_r  <= meta_r;
            prev_r  <= sync_r;
            pulse_r <= sync_r & ~prev_r;
        end
    end

    assign pulse = pulse_r;

endmodule

// File: rtl/sync_gen.sv
// Sync-strobe initiator: internal-period or external-trigger strobes with min width, hold-off and bursts.
// Define SYNC_GEN_EXT_TRIG_EN to compile in the external-trigger path (synchroniser, WAIT state, miss logic).
module sync_gen
    import dscope_sync_pkg::*;
#(
    parameter int PERIOD_W = 32,
    parameter int PULSE_W  = DEF_PULSE_W,
    parameter int HOLDOFF  = DEF_HOLDOFF
) (
    input  logic                sys_clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic                i_ext_mode,
    input  logic [PERIOD_W-1:0] i_period,
    input  logic [BURST_W-1:0]  i_burst,
    input  logic                i_ext_trig,
    output logic                o_sync,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_missed,
    output logic [PERIOD_W-1:0] o_sync_cnt,
    output logic [BURST_W-1:0]  o_miss_cnt
);

    localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(PULSE_W + HOLDOFF);
    localparam logic [PERIOD_W-1:0] PULSE_END  = PERIOD_W'(PULSE_W - 1);
    localparam logic [PERIOD_W-1:0] HOLD_END   = PERIOD_W'(PULSE_W + HOLDOFF - 1);
    localparam logic [PERIOD_W-1:0] ONE        = PERIOD_W'(1);

    sync_state_e         state_r;
    logic                ext_mode_r;
    logic [PERIOD_W-1:0] period_r;
    logic [BURST_W-1:0]  burst_r;
    logic [PERIOD_W-1:0] cnt_r;
    logic                stop_pend_r;
    logic                sync_r;
    logic                busy_r;
    logic                done_r;
    logic [PERIOD_W-1:0] sync_cnt_r;

    logic                trig_s;
    logic                mode_s;
    logic                start_acc_s;
    logic                burst_hit_s;
    logic [PERIOD_W-1:0] eff_period_s;

`ifdef SYNC_GEN_EXT_TRIG_EN
    logic               missed_r;
    logic [BURST_W-1:0] miss_cnt_r;

    trig_sync u_trig_sync (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .async_in (i_ext_trig),
        .pulse    (trig_s)
    );

    assign mode_s = i_ext_mode;

    // Rejected-edge reporting: edges detected while a strobe or its hold-off is in progress.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            missed_r   <= 1'b0;
            miss_cnt_r <= {BURST_W{1'b0}};
        end else begin
            missed_r <= 1'b0;
            if (start_acc_s) begin
                miss_cnt_r <= {BURST_W{1'b0}};
            end else if (trig_s && ext_mode_r && (state_r == ST_PULSE || state_r == ST_HOLD)) begin
                missed_r   <= 1'b1;
                miss_cnt_r <= sat_inc(miss_cnt_r);
            end else begin
                miss_cnt_r <= miss_cnt_r;
            end
        end
    end

    assign o_missed   = missed_r;
    assign o_miss_cnt = miss_cnt_r;
`else
    logic unused_ext_s;

    assign unused_ext_s = i_ext_mode ^ i_ext_trig;
    assign trig_s       = 1'b0;
    assign mode_s       = 1'b0;
    assign o_missed     = 1'b0;
    assign o_miss_cnt   = {BURST_W{1'b0}};
`endif

    assign start_acc_s = i_start & ~i_stop & (state_r == ST_IDLE);
    assign burst_hit_s = (burst_r != 16'd0) && (sync_cnt_r == PERIOD_W'(burst_r));

    // Clamp the requested period (including zero) up to the minimum pulse-plus-hold-off spacing.
    always_comb begin
        eff_period_s = i_period;
        if (i_period < MIN_PERIOD) begin
            eff_period_s = MIN_PERIOD;
        end else begin
            eff_period_s = i_period;
        end
    end

    // Main strobe sequencer; cnt_r counts cycles since the current pulse began.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            ext_mode_r  <= 1'b0;
            period_r    <= {PERIOD_W{1'b0}};
            burst_r     <= {BURST_W{1'b0}};
            cnt_r       <= {PERIOD_W{1'b0}};
            stop_pend_r <= 1'b0;
            sync_r      <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            sync_cnt_r  <= {PERIOD_W{1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_acc_s) begin
                        ext_mode_r  <= mode_s;
                        period_r    <= eff_period_s;
                        burst_r     <= i_burst;
                        cnt_r       <= {PERIOD_W{1'b0}};
                        stop_pend_r <= 1'b0;
                        busy_r      <= 1'b1;
                        if (mode_s) begin
                            state_r    <= ST_WAIT;
                            sync_cnt_r <= {PERIOD_W{1'b0}};
                        end else begin
                            state_r    <= ST_PULSE;
                            sync_r     <= 1'b1;
                            sync_cnt_r <= ONE;
                        end
                    end
                end
`ifdef SYNC_GEN_EXT_TRIG_EN
                ST_WAIT: begin
                    if (i_stop) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else if (trig_s) begin
                        state_r    <= ST_PULSE;
                        sync_r     <= 1'b1;
                        cnt_r      <= {PERIOD_W{1'b0}};
                        sync_cnt_r <= sync_cnt_r + ONE;
                    end
                end
`endif
                ST_PULSE: begin
                    cnt_r       <= cnt_r + ONE;
                    stop_pend_r <= stop_pend_r | i_stop;
                    if (cnt_r == PULSE_END) begin
                        sync_r <= 1'b0;
                        if (stop_pend_r | i_stop) begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (i_stop || (cnt_r == HOLD_END && burst_hit_s)) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else if (cnt_r == HOLD_END && ext_mode_r) begin
                        state_r <= ST_WAIT;
                    end else if (!ext_mode_r && cnt_r == period_r - ONE) begin
                        state_r    <= ST_PULSE;
                        sync_r     <= 1'b1;
                        cnt_r      <= {PERIOD_W{1'b0}};
                        sync_cnt_r <= sync_cnt_r + ONE;
                    end else begin
                        cnt_r <= cnt_r + ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    sync_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign o_sync     = sync_r;
    assign o_busy     = busy_r;
    assign o_done     = done_r;
    assign o_sync_cnt = sync_cnt_r;

endmodule

// File: tb/tb_sync_gen.sv
// Self-checking bench for sync_gen: expected waveforms are derived arithmetically from the strobe rules.
module tb_sync_gen;
    import dscope_sync_pkg::*;

    localparam int PW   = 4;
    localparam int HO   = 16;
    localparam int MAXC = 320;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_stop = 1'b0;
    logic        i_ext_mode = 1'b0;
    logic [31:0] i_period = 32'd0;
    logic [15:0] i_burst = 16'd0;
    logic        i_ext_trig = 1'b0;
    logic        o_sync, o_busy, o_done, o_missed;
    logic [31:0] o_sync_cnt;
    logic [15:0] o_miss_cnt;

    always #5 sys_clk = ~sys_clk;

    sync_gen #(.PERIOD_W(32), .PULSE_W(PW), .HOLDOFF(HO)) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_stop     (i_stop),
        .i_ext_mode (i_ext_mode),
        .i_period   (i_period),
        .i_burst    (i_burst),
        .i_ext_trig (i_ext_trig),
        .o_sync     (o_sync),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_missed   (o_missed),
        .o_sync_cnt (o_sync_cnt),
        .o_miss_cnt (o_miss_cnt)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ncyc, g_end, g_stop, g_xs;
    bit e_sync[MAXC], e_busy[MAXC], e_done[MAXC], e_miss[MAXC], trig_w[MAXC];
    int e_cnt[MAXC], e_mcnt[MAXC];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic int eff_of(input int p);
        return (p < PW + HO) ? PW + HO : p;
    endfunction

    // Internal mode: rising edges at 1 + n*eff; natural end after last pulse plus hold-off.
    task automatic build_internal(input int period, input int burst, input int stop_s);
        int eff, end_c, sn, so, last;
        eff   = eff_of(period);
        end_c = (burst > 0) ? 1 + (burst - 1) * eff + PW + HO : MAXC + 10;
        if (stop_s >= 1 && stop_s < end_c) begin
            sn = (stop_s - 1) / eff;
            so = (stop_s - 1) % eff;
            end_c = (so < PW) ? 1 + sn * eff + PW : stop_s + 1;
        end
        for (int c = 0; c < MAXC; c++) begin
            last      = (c < end_c) ? c : end_c - 1;
            e_busy[c] = (c >= 1) && (c < end_c);
            e_sync[c] = e_busy[c] && (((c - 1) % eff) < PW);
            e_done[c] = (c == end_c);
            e_cnt[c]  = (last >= 1) ? (last - 1) / eff + 1 : 0;
            e_miss[c] = 1'b0;
            e_mcnt[c] = 0;
`ifdef SYNC_GEN_EXT_TRIG_EN
            trig_w[c] = 1'b0;
`else
            trig_w[c] = bit'($urandom_range(0, 1));
`endif
        end
        g_stop = stop_s;
        g_end  = end_c;
        ncyc   = (end_c + 4 < MAXC) ? end_c + 4 : MAXC - 1;
    endtask

    // External mode: edge sampled at posedge k is acted on at posedge k+3; accepted only when waiting.
    task automatic build_ext(input int burst, input int ks[$]);
        int ready, end_c, got, lastdc, dc;
        int strobes[$];
        int misses[$];
        ready = 1; end_c = MAXC + 10; got = 0; lastdc = 0;
        foreach (ks[i]) begin
            dc = ks[i] + 2;
            lastdc = dc;
            if (dc < end_c) begin
                if (dc >= ready) begin
                    strobes.push_back(dc + 1);
                    got++;
                    ready = dc + 1 + PW + HO;
                    if (got == burst) end_c = ready;
                end else if (dc >= 1) begin
                    misses.push_back(dc + 1);
                end
            end
        end
        g_stop = -1;
        if (got < burst) begin
            g_stop = ((ready > lastdc + 1) ? ready : lastdc + 1) + 2;
            end_c  = g_stop + 1;
        end
        for (int c = 0; c < MAXC; c++) begin
            e_busy[c] = (c >= 1) && (c < end_c);
            e_done[c] = (c == end_c);
            e_sync[c] = 1'b0; e_cnt[c] = 0; e_miss[c] = 1'b0; e_mcnt[c] = 0; trig_w[c] = 1'b0;
            foreach (strobes[j]) begin
                if (strobes[j] <= c) e_cnt[c]++;
                if (c >= strobes[j] && c < strobes[j] + PW) e_sync[c] = 1'b1;
            end
            foreach (misses[j]) begin
                if (misses[j] <= c) e_mcnt[c]++;
                if (misses[j] == c) e_miss[c] = 1'b1;
            end
        end
        foreach (ks[i]) for (int d = -1; d <= 1; d++) trig_w[ks[i] + d] = 1'b1;
        g_end = end_c;
        ncyc  = end_c + 4;
    endtask

    // Drive one run from cycle 0 (start) and compare every cycle against the expected arrays.
    task automatic execute(input bit mode, input int period, input int burst);
        for (int c = 0; c <= ncyc; c++) begin
            cyc = c;
            if (c == 0) begin
                chk("idle_busy", o_busy, 32'd0);
            end else begin
                chk("sync", o_sync, 32'(e_sync[c]));
                chk("busy", o_busy, 32'(e_busy[c]));
                chk("done", o_done, 32'(e_done[c]));
                chk("missed", o_missed, 32'(e_miss[c]));
                chk("sync_cnt", o_sync_cnt, 32'(e_cnt[c]));
                chk("miss_cnt", o_miss_cnt, 32'(e_mcnt[c]));
            end
            i_start    = (c == 0) || (c == g_xs);
            i_stop     = (c == g_stop);
            i_ext_mode = (c == 0) ? mode : 1'($urandom);
            i_period   = (c == 0) ? 32'(period) : 32'($urandom_range(0, 300));
            i_burst    = (c == 0) ? 16'(burst) : 16'($urandom);
            i_ext_trig = trig_w[c];
            tick();
        end
        i_start = 1'b0; i_stop = 1'b0; i_ext_trig = 1'b0; i_ext_mode = 1'b0;
    endtask

    initial begin
        int p, b, s, k;
        int ks[$];

        tick(); tick();
        chk("rst_sync", o_sync, 32'd0);
        chk("rst_busy", o_busy, 32'd0);
        chk("rst_done", o_done, 32'd0);
        chk("rst_missed", o_missed, 32'd0);
        chk("rst_sync_cnt", o_sync_cnt, 32'd0);
        chk("rst_miss_cnt", o_miss_cnt, 32'd0);
        rst = 1'b0;
        tick(); tick();

        g_xs = -1;
        build_internal(100, 3, -1);
        execute(1'b0, 100, 3);

        build_internal(5, 0, 63);
        execute(1'b0, 5, 0);

        // Start and stop together while idle: stop wins.
        i_start = 1'b1; i_stop = 1'b1; i_period = 32'd30; i_burst = 16'd1;
        tick();
        i_start = 1'b0; i_stop = 1'b0;
        for (int c = 0; c < 25; c++) begin
            cyc = c;
            chk("ss_busy", o_busy, 32'd0);
            chk("ss_sync", o_sync, 32'd0);
            tick();
        end

        // Start while busy must not re-latch the period.
        build_internal(30, 2, -1);
        g_xs = 15;
        execute(1'b0, 30, 2);
        g_xs = -1;

        // Reset mid-pulse, then a fresh run.
        i_start = 1'b1; i_period = 32'd100; i_burst = 16'd3;
        tick();
        i_start = 1'b0;
        tick();
        cyc = 2;
        chk("pre_rst_sync", o_sync, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_sync", o_sync, 32'd0);
        chk("arst_busy", o_busy, 32'd0);
        chk("arst_sync_cnt", o_sync_cnt, 32'd0);
        chk("arst_miss_cnt", o_miss_cnt, 32'd0);
        tick();
        rst = 1'b0;
        tick(); tick();
        build_internal(100, 3, -1);
        execute(1'b0, 100, 3);

`ifdef SYNC_GEN_EXT_TRIG_EN
        ks = '{10, 18, 50};
        build_ext(2, ks);
        execute(1'b1, 0, 2);
        for (int r = 0; r < 3; r++) begin
            ks.delete();
            k = $urandom_range(3, 10);
            for (int j = 0; j < 5; j++) begin
                ks.push_back(k);
                k += $urandom_range(5, 30);
            end
            b = $urandom_range(1, 3);
            build_ext(b, ks);
            execute(1'b1, 0, b);
            tick(); tick();
        end
`else
        build_internal(30, 3, -1);
        execute(1'b1, 30, 3);
`endif

        for (int r = 0; r < 8; r++) begin
            p = $urandom_range(0, 60);
            b = $urandom_range(0, 4);
            if (b == 0) s = $urandom_range(1, 150);
            else s = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(1, b * eff_of(p) + 30);
            build_internal(p, b, s);
            g_xs = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(1, g_end - 1);
            execute(1'b0, p, b);
            g_xs = -1;
            tick(); tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
